// File: rtl/pipeline_cpu_top.sv
// 5-stage in-order RV32I-subset core: F, D, E, M, W.
// Holds the instruction ROM, register file, ALU, data RAM, forwarding and flush logic.
// The ROM image is supplied through the IMEM_INIT parameter. It is constant, so fetch
// is a pure combinational lookup. There is no load-use interlock: software spaces
// every lw consumer at least two slots after the load.
module pipeline_cpu_top #(
  parameter int          IMEM_WORDS = 1024,
  parameter int          DMEM_WORDS = 1024,
  parameter logic [31:0] IMEM_INIT [IMEM_WORDS] = '{default: 32'h0000_0013}
) (
  input logic clk,
  input logic rst
);

  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } if_id_t;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic        mem_write;
    logic        branch;
    logic        alu_src;
    logic [2:0]  alu_ctrl;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic        mem_write;
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    logic        reg_write;
    logic        result_src;
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [4:0]  rd;
  } mem_wb_t;

  logic [31:0] pc, instr_f, pc_target_e, result_w, read_data_m;
  logic        pc_src_e;
  if_id_t      if_id;
  id_ex_t      id_ex;
  ex_mem_t     ex_mem;
  mem_wb_t     mem_wb;
  logic [31:0] rf   [32];
  logic [31:0] dmem [DMEM_WORDS];

  // ---------------- Fetch ----------------
  assign instr_f = IMEM_INIT[pc[IAW+1:2]];

  // PC: redirect to the branch target when E resolves a taken branch
  always_ff @(posedge clk) begin
    if (rst)           pc <= '0;
    else if (pc_src_e) pc <= pc_target_e;
    else               pc <= pc + 32'd4;
  end

  // IF/ID register; a taken branch turns the wrong-path fetch into a bubble
  always_ff @(posedge clk) begin
    if (rst || pc_src_e) if_id <= '0;
    else                 if_id <= '{instr: instr_f, pc: pc};
  end

  // ---------------- Decode ----------------
  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        reg_write_d, result_src_d, mem_write_d, branch_d, alu_src_d;
  logic [2:0]  alu_ctrl_d, alu_f3;
  logic        f3_ok;
  logic [1:0]  imm_src_d;
  logic [31:0] imm_d, rd1_d, rd2_d;

  assign opcode = if_id.instr[6:0];
  assign f3     = if_id.instr[14:12];
  assign rd_d   = if_id.instr[11:7];
  assign rs1_d  = if_id.instr[19:15];
  assign rs2_d  = if_id.instr[24:20];

  // ALU op shared by R-type and I-type arithmetic; unsupported funct3 decodes as NOP
  always_comb begin
    f3_ok  = 1'b1;
    alu_f3 = 3'b000;
    case (f3)
      3'b000:  alu_f3 = 3'b000;
      3'b010:  alu_f3 = 3'b101;
      3'b110:  alu_f3 = 3'b011;
      3'b111:  alu_f3 = 3'b010;
      default: f3_ok  = 1'b0;
    endcase
  end

  // Main decoder; anything unrecognised leaves every write/branch control low
  always_comb begin
    reg_write_d  = 1'b0;
    result_src_d = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    alu_src_d    = 1'b0;
    alu_ctrl_d   = 3'b000;
    imm_src_d    = 2'b00;
    case (opcode)
      7'b0000011: if (f3 == 3'b010) begin
        reg_write_d = 1'b1; result_src_d = 1'b1; alu_src_d = 1'b1;
      end
      7'b0100011: if (f3 == 3'b010) begin
        mem_write_d = 1'b1; alu_src_d = 1'b1; imm_src_d = 2'b01;
      end
      7'b0110011: if (f3_ok) begin
        reg_write_d = 1'b1;
        alu_ctrl_d  = (f3 == 3'b000 && if_id.instr[30]) ? 3'b001 : alu_f3;
      end
      7'b0010011: if (f3_ok) begin
        reg_write_d = 1'b1; alu_src_d = 1'b1; alu_ctrl_d = alu_f3;
      end
      7'b1100011: if (f3 == 3'b000) begin
        branch_d = 1'b1; alu_ctrl_d = 3'b001; imm_src_d = 2'b10;
      end
      default: ;
    endcase
  end

  // Sign-extended immediates for I, S and B formats
  always_comb begin
    case (imm_src_d)
      2'b00:   imm_d = {{20{if_id.instr[31]}}, if_id.instr[31:20]};
      2'b01:   imm_d = {{20{if_id.instr[31]}}, if_id.instr[31:25], if_id.instr[11:7]};
      2'b10:   imm_d = {{19{if_id.instr[31]}}, if_id.instr[31], if_id.instr[7],
                        if_id.instr[30:25], if_id.instr[11:8], 1'b0};
      default: imm_d = '0;
    endcase
  end

  // Register reads: x0 is zero, and a same-cycle W write is passed straight through
  always_comb begin
    rd1_d = rf[rs1_d];
    rd2_d = rf[rs2_d];
    if (mem_wb.reg_write && mem_wb.rd == rs1_d) rd1_d = result_w;
    if (mem_wb.reg_write && mem_wb.rd == rs2_d) rd2_d = result_w;
    if (rs1_d == 5'd0) rd1_d = '0;
    if (rs2_d == 5'd0) rd2_d = '0;
  end

  // Register file write port; writes to x0 are dropped so rf[0] stays zero
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (mem_wb.reg_write && mem_wb.rd != 5'd0) begin
      rf[mem_wb.rd] <= result_w;
    end
  end

  // ID/EX register; flushed together with IF/ID on a taken branch
  always_ff @(posedge clk) begin
    if (rst || pc_src_e) id_ex <= '0;
    else id_ex <= '{reg_write: reg_write_d, result_src: result_src_d, mem_write: mem_write_d,
                    branch: branch_d, alu_src: alu_src_d, alu_ctrl: alu_ctrl_d,
                    rd1: rd1_d, rd2: rd2_d, imm: imm_d, pc: if_id.pc,
                    rs1: rs1_d, rs2: rs2_d, rd: rd_d};
  end

  // ---------------- Execute ----------------
  logic [31:0] src_a_e, src_b_e, write_data_e, alu_result_e;

  // Operand forwarding, M has priority over W
  always_comb begin
    src_a_e      = id_ex.rd1;
    write_data_e = id_ex.rd2;
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs1) src_a_e = result_w;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs1) src_a_e = ex_mem.alu_result;
    if (mem_wb.reg_write && mem_wb.rd != 5'd0 && mem_wb.rd == id_ex.rs2) write_data_e = result_w;
    if (ex_mem.reg_write && ex_mem.rd != 5'd0 && ex_mem.rd == id_ex.rs2) write_data_e = ex_mem.alu_result;
  end

  assign src_b_e = id_ex.alu_src ? id_ex.imm : write_data_e;

  // ALU, 32-bit wrap-around
  always_comb begin
    case (id_ex.alu_ctrl)
      3'b000:  alu_result_e = src_a_e + src_b_e;
      3'b001:  alu_result_e = src_a_e - src_b_e;
      3'b010:  alu_result_e = src_a_e & src_b_e;
      3'b011:  alu_result_e = src_a_e | src_b_e;
      3'b101:  alu_result_e = {31'd0, $signed(src_a_e) < $signed(src_b_e)};
      default: alu_result_e = '0;
    endcase
  end

  assign pc_src_e    = id_ex.branch && (alu_result_e == 32'd0);
  assign pc_target_e = id_ex.pc + id_ex.imm;

  // EX/MEM register
  always_ff @(posedge clk) begin
    if (rst) ex_mem <= '0;
    else ex_mem <= '{reg_write: id_ex.reg_write, result_src: id_ex.result_src,
                     mem_write: id_ex.mem_write, alu_result: alu_result_e,
                     write_data: write_data_e, rd: id_ex.rd};
  end

  // ---------------- Memory ----------------
  assign read_data_m = dmem[ex_mem.alu_result[DAW+1:2]];

  // Data RAM write; not cleared by reset, but an in-flight store is dropped on a reset edge
  always_ff @(posedge clk) begin
    if (!rst && ex_mem.mem_write) dmem[ex_mem.alu_result[DAW+1:2]] <= ex_mem.write_data;
  end

  // MEM/WB register
  always_ff @(posedge clk) begin
    if (rst) mem_wb <= '0;
    else mem_wb <= '{reg_write: ex_mem.reg_write, result_src: ex_mem.result_src,
                     alu_result: ex_mem.alu_result, read_data: read_data_m, rd: ex_mem.rd};
  end

  // ---------------- Writeback ----------------
  assign result_w = mem_wb.result_src ? mem_wb.read_data : mem_wb.alu_result;

  // Address bits below word granularity and above memory depth are ignored
  logic unused_bits;
  assign unused_bits = ^{pc[1:0], pc[31:IAW+2], ex_mem.alu_result[1:0],
                         ex_mem.alu_result[31:DAW+2]};

endmodule

// File: tb/tb_pipeline_cpu_top.sv
// Directed bench for pipeline_cpu_top: one program in ROM, each task restarts from
// reset, runs a known number of edges and checks architectural state hierarchically.
module tb_pipeline_cpu_top;

  function automatic logic [31:0] i_op(int f3, int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0010011};
  endfunction
  function automatic logic [31:0] r_op(int f7, int f3, int rd, int rs1, int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction
  function automatic logic [31:0] lw_op(int rd, int rs1, int imm);
    return {imm[11:0], rs1[4:0], 3'b010, rd[4:0], 7'b0000011};
  endfunction
  function automatic logic [31:0] sw_op(int rs2, int rs1, int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] beq_op(int rs1, int rs2, int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], 3'b000, imm[4:1], imm[11], 7'b1100011};
  endfunction

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] PROG [1024] = '{
    0:  i_op(0, 1, 0, 5),        // addi x1,x0,5
    1:  i_op(0, 2, 0, 7),        // addi x2,x0,7
    2:  r_op(0, 0, 3, 1, 2),     // add  x3,x1,x2
    3:  i_op(0, 4, 0, -1),       // addi x4,x0,-1
    4:  r_op(0, 2, 5, 4, 0),     // slt  x5,x4,x0
    5:  r_op(32, 0, 6, 0, 4),    // sub  x6,x0,x4
    6:  i_op(0, 11, 0, 240),     // addi x11,x0,0xF0
    7:  i_op(0, 12, 0, 15),      // addi x12,x0,0x0F
    8:  r_op(0, 6, 13, 11, 12),  // or   x13,x11,x12
    9:  r_op(0, 7, 14, 11, 12),  // and  x14,x11,x12
    10: sw_op(3, 0, 8),          // sw   x3,8(x0)
    11: NOP,
    12: lw_op(7, 0, 8),          // lw   x7,8(x0)
    13: NOP,
    14: r_op(0, 0, 8, 7, 7),     // add  x8,x7,x7
    15: beq_op(1, 1, 8),         // beq  x1,x1,+8 (taken)
    16: i_op(0, 9, 0, 1),        // addi x9,x0,1 (shadow)
    17: i_op(0, 15, 0, 3),       // addi x15,x0,3 (target)
    18: beq_op(1, 2, 8),         // beq  x1,x2,+8 (not taken)
    19: i_op(0, 16, 0, 4),       // addi x16,x0,4
    20: i_op(0, 0, 0, 9),        // addi x0,x0,9
    21: r_op(0, 0, 10, 0, 0),    // add  x10,x0,x0
    22: i_op(7, 17, 13, 15),     // andi x17,x13,0x0F
    23: i_op(6, 18, 0, 256),     // ori  x18,x0,0x100
    24: i_op(2, 19, 4, 1),       // slti x19,x4,1
    25: beq_op(0, 0, 0),         // loop: beq x0,x0,0
    default: NOP
  };

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  pipeline_cpu_top #(.IMEM_WORDS(1024), .DMEM_WORDS(1024), .IMEM_INIT(PROG)) dut (
    .clk(clk),
    .rst(rst)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic restart();
    rst = 1'b1;
    step(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [6:0] bub;
    rst = 1'b1;
    step(2);
    bub = {|dut.if_id.instr, dut.id_ex.reg_write, dut.id_ex.mem_write, dut.id_ex.branch,
           dut.ex_mem.reg_write, dut.ex_mem.mem_write, dut.mem_wb.reg_write};
    n_checks++; if (dut.pc !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", dut.pc); end
    n_checks++; if (bub !== 7'd0) begin n_fail++; $display("FAIL reset_bubbles: got %b want 0", bub); end
    n_checks++; if (dut.instr_f !== PROG[0]) begin n_fail++; $display("FAIL first_fetch: got %h want %h", dut.instr_f, PROG[0]); end
    rst = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step(1);
      n_checks++;
      if (dut.pc !== 32'(4 * k)) begin n_fail++; $display("FAIL pc_seq%0d: got %h want %h", k, dut.pc, 4 * k); end
    end
  endtask

  task automatic test_back_to_back();
    restart();
    step(4);
    n_checks++; if (dut.rf[1] !== 32'd0) begin n_fail++; $display("FAIL x1_early: got %h want 0", dut.rf[1]); end
    step(1);
    n_checks++; if (dut.rf[1] !== 32'd5) begin n_fail++; $display("FAIL x1_edge5: got %h want 5", dut.rf[1]); end
    step(1);
    n_checks++; if (dut.rf[2] !== 32'd7) begin n_fail++; $display("FAIL x2_edge6: got %h want 7", dut.rf[2]); end
    step(1);
    n_checks++; if (dut.rf[3] !== 32'd12) begin n_fail++; $display("FAIL x3_fwd_edge7: got %h want c", dut.rf[3]); end
  endtask

  task automatic test_alu();
    restart();
    step(20);
    n_checks++; if (dut.rf[4] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL x4_neg1: got %h want ffffffff", dut.rf[4]); end
    n_checks++; if (dut.rf[5] !== 32'd1) begin n_fail++; $display("FAIL slt_x5: got %h want 1", dut.rf[5]); end
    n_checks++; if (dut.rf[6] !== 32'd1) begin n_fail++; $display("FAIL sub_x6: got %h want 1", dut.rf[6]); end
    n_checks++; if (dut.rf[13] !== 32'hFF) begin n_fail++; $display("FAIL or_x13: got %h want ff", dut.rf[13]); end
    n_checks++; if (dut.rf[14] !== 32'd0) begin n_fail++; $display("FAIL and_x14: got %h want 0", dut.rf[14]); end
  endtask

  task automatic test_mem();
    restart();
    step(20);
    n_checks++; if (dut.dmem[2] !== 32'd12) begin n_fail++; $display("FAIL sw_word2: got %h want c", dut.dmem[2]); end
    n_checks++; if (dut.rf[7] !== 32'd12) begin n_fail++; $display("FAIL lw_x7: got %h want c", dut.rf[7]); end
    n_checks++; if (dut.rf[8] !== 32'd24) begin n_fail++; $display("FAIL load_use_x8: got %h want 18", dut.rf[8]); end
  endtask

  task automatic test_branch();
    logic [32:0] flushed;
    restart();
    step(18);
    n_checks++; if (dut.pc !== 32'd68) begin n_fail++; $display("FAIL beq_redirect: got %h want 44", dut.pc); end
    flushed = {dut.if_id.instr, dut.id_ex.reg_write};
    n_checks++; if (flushed !== 33'd0) begin n_fail++; $display("FAIL beq_flush: got %h want 0", flushed); end
    step(1);
    n_checks++; if (dut.pc !== 32'd72) begin n_fail++; $display("FAIL after_target: got %h want 48", dut.pc); end
    step(16);
    n_checks++; if (dut.rf[9] !== 32'd0) begin n_fail++; $display("FAIL shadow_x9: got %h want 0", dut.rf[9]); end
    n_checks++; if (dut.rf[15] !== 32'd3) begin n_fail++; $display("FAIL target_x15: got %h want 3", dut.rf[15]); end
    n_checks++; if (dut.rf[16] !== 32'd4) begin n_fail++; $display("FAIL not_taken_x16: got %h want 4", dut.rf[16]); end
    n_checks++; if (dut.rf[17] !== 32'h0F) begin n_fail++; $display("FAIL andi_x17: got %h want f", dut.rf[17]); end
    n_checks++; if (dut.rf[18] !== 32'h100) begin n_fail++; $display("FAIL ori_x18: got %h want 100", dut.rf[18]); end
    n_checks++; if (dut.rf[19] !== 32'd1) begin n_fail++; $display("FAIL slti_x19: got %h want 1", dut.rf[19]); end
  endtask

  task automatic test_x0_midreset();
    logic [31:0] acc;
    logic [6:0]  bub;
    restart();
    step(40);
    n_checks++; if (dut.rf[0] !== 32'd0) begin n_fail++; $display("FAIL x0_write: got %h want 0", dut.rf[0]); end
    n_checks++; if (dut.rf[10] !== 32'd0) begin n_fail++; $display("FAIL x10_read_x0: got %h want 0", dut.rf[10]); end
    n_checks++; if (!(dut.pc inside {32'd100, 32'd104, 32'd108})) begin n_fail++; $display("FAIL loop_pc: got %h want 64/68/6c", dut.pc); end
    rst = 1'b1;
    step(1);
    acc = '0;
    for (int i = 1; i < 32; i++) acc |= dut.rf[i];
    bub = {|dut.if_id.instr, dut.id_ex.reg_write, dut.id_ex.mem_write, dut.id_ex.branch,
           dut.ex_mem.reg_write, dut.ex_mem.mem_write, dut.mem_wb.reg_write};
    n_checks++; if (dut.pc !== 32'd0) begin n_fail++; $display("FAIL midreset_pc: got %h want 0", dut.pc); end
    n_checks++; if (bub !== 7'd0) begin n_fail++; $display("FAIL midreset_bubbles: got %b want 0", bub); end
    n_checks++; if (acc !== 32'd0) begin n_fail++; $display("FAIL midreset_regs: got %h want 0", acc); end
    n_checks++; if (dut.dmem[2] !== 32'd12) begin n_fail++; $display("FAIL ram_kept: got %h want c", dut.dmem[2]); end
    rst = 1'b0;
    step(1);
    n_checks++; if (dut.pc !== 32'd4) begin n_fail++; $display("FAIL restart_pc: got %h want 4", dut.pc); end
    step(4);
    n_checks++; if (dut.rf[1] !== 32'd5) begin n_fail++; $display("FAIL restart_x1: got %h want 5", dut.rf[1]); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_alu();
    test_mem();
    test_branch();
    test_x0_midreset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
